// File: rtl/btn_cond_ena_gen_pkg.sv
// Shared constants, FSM state type and counter-width helper for the
// button conditioning / enable generation front end.
package btn_cond_ena_gen_pkg;

  // System clock frequency the default timing constants are derived from
  localparam int unsigned CLK_HZ = 50_000_000;

  // Button bit positions
  localparam int BTN_MOD = 0;
  localparam int BTN_UP  = 1;
  localparam int BTN_DW  = 2;
  localparam int BTN_PS  = 3;

  // Default timing constants (cycles of ckht)
  localparam int          N_BTN_DEF       = 4;
  localparam int unsigned DB_CYC_DEF      = 1_000_000;   // 20 ms
  localparam int unsigned ENA_DIV_DEF     = 25_000_000;  // 2 Hz
  localparam int unsigned SCAN_DIV_DEF    = 50_000;      // 1 kHz
  localparam int unsigned REP_DLY_CYC_DEF = 25_000_000;  // 500 ms
  localparam int unsigned REP_CYC_DEF     = 10_000_000;  // 200 ms
  localparam logic [3:0]  REP_EN_DEF      = 4'b0110;     // up and down repeat

  // Per-button auto-repeat state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rep_state_t;

  // Width of a counter that must reach n-1; never narrower than one bit
  function automatic int cnt_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_cond_ena_gen_btn_chan.sv
// One button channel: 2-flop synchroniser, debounce filter, press edge
// pulse and optional auto-repeat FSM. Output pulse o_cdb is registered.
module btn_chan
  import btn_cond_ena_gen_pkg::*;
#(
  parameter int unsigned DB_CYC      = DB_CYC_DEF,
  parameter int unsigned REP_DLY_CYC = REP_DLY_CYC_DEF,
  parameter int unsigned REP_CYC     = REP_CYC_DEF,
  parameter bit          REP_ON      = 1'b0
) (
  input  logic i_ckht,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_btn_lvl,
  output logic o_cdb
);

  localparam int DB_W  = cnt_w(DB_CYC);
  localparam int REP_W = cnt_w((REP_DLY_CYC > REP_CYC) ? REP_DLY_CYC : REP_CYC);

  localparam logic [DB_W-1:0]  DB_TERM  = DB_W'(DB_CYC - 1);
  localparam logic [REP_W-1:0] DLY_TERM = REP_W'(REP_DLY_CYC - 1);
  localparam logic [REP_W-1:0] RPT_TERM = REP_W'(REP_CYC - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_lvl;
  logic             r_lvl_d;
  logic             r_cdb;
  logic [REP_W-1:0] r_rep_cnt;
  rep_state_t       r_state;
  logic             w_rise;

  // Bring the asynchronous raw input into the ckht domain
  always_ff @(posedge i_ckht or negedge i_rst) begin
    if (!i_rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn_raw;
      r_sync1 <= r_sync0;
    end
  end

  // Accept a new level only after DB_CYC consecutive differing samples
  always_ff @(posedge i_ckht or negedge i_rst) begin
    if (!i_rst) begin
      r_db_cnt <= '0;
      r_lvl    <= 1'b0;
    end else if (r_sync1 == r_lvl) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_TERM) begin
      r_lvl    <= r_sync1;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_rise = r_lvl & ~r_lvl_d;

  // Press pulse plus repeat FSM; a released button always wins over a
  // terminal count landing in the same cycle
  always_ff @(posedge i_ckht or negedge i_rst) begin
    if (!i_rst) begin
      r_lvl_d   <= 1'b0;
      r_cdb     <= 1'b0;
      r_rep_cnt <= '0;
      r_state   <= ST_IDLE;
    end else begin
      r_lvl_d <= r_lvl;
      r_cdb   <= 1'b0;
      if (!r_lvl) begin
        r_state   <= ST_IDLE;
        r_rep_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_cdb     <= 1'b1;
              r_rep_cnt <= '0;
              if (REP_ON) begin
                r_state <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (r_rep_cnt == DLY_TERM) begin
              r_cdb     <= 1'b1;
              r_rep_cnt <= '0;
              r_state   <= ST_RPT;
            end else begin
              r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
          end
          ST_RPT: begin
            if (r_rep_cnt == RPT_TERM) begin
              r_cdb     <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_rep_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign o_btn_lvl = r_lvl;
  assign o_cdb     = r_cdb;

endmodule

// File: rtl/btn_cond_ena_gen.sv
// Button conditioning front end: per-button debounce / press pulse /
// auto-repeat channels plus the free-running ena2hz and scan strobes.
module btn_cond_ena_gen
  import btn_cond_ena_gen_pkg::*;
#(
  parameter int               N_BTN       = N_BTN_DEF,
  parameter int unsigned      DB_CYC      = DB_CYC_DEF,
  parameter int unsigned      ENA_DIV     = ENA_DIV_DEF,
  parameter int unsigned      SCAN_DIV    = SCAN_DIV_DEF,
  parameter int unsigned      REP_DLY_CYC = REP_DLY_CYC_DEF,
  parameter int unsigned      REP_CYC     = REP_CYC_DEF,
  parameter logic [N_BTN-1:0] REP_EN      = N_BTN'(REP_EN_DEF)
) (
  input  logic             ckht,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_lvl,
  output logic [N_BTN-1:0] cdb,
  output logic             ena2hz,
  output logic             ena_scan
);

  localparam int ENA_W  = cnt_w(ENA_DIV);
  localparam int SCAN_W = cnt_w(SCAN_DIV);

  localparam logic [ENA_W-1:0]  ENA_TERM  = ENA_W'(ENA_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_TERM = SCAN_W'(SCAN_DIV - 1);

  logic [ENA_W-1:0]  r_ena_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic              r_ena2hz;
  logic              r_ena_scan;

  // Independent channel per button; no arbitration between them
  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      btn_chan #(
        .DB_CYC      (DB_CYC),
        .REP_DLY_CYC (REP_DLY_CYC),
        .REP_CYC     (REP_CYC),
        .REP_ON      (REP_EN[gi])
      ) u_chan (
        .i_ckht    (ckht),
        .i_rst     (rst),
        .i_btn_raw (btn_raw[gi]),
        .o_btn_lvl (btn_lvl[gi]),
        .o_cdb     (cdb[gi])
      );
    end
  endgenerate

  // ena2hz divider: registered strobe on the terminal count, first one
  // ENA_DIV cycles after reset release
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      r_ena_cnt <= '0;
      r_ena2hz  <= 1'b0;
    end else begin
      r_ena2hz <= (r_ena_cnt == ENA_TERM);
      if (r_ena_cnt == ENA_TERM) begin
        r_ena_cnt <= '0;
      end else begin
        r_ena_cnt <= r_ena_cnt + ENA_W'(1);
      end
    end
  end

  // Display-scan divider, same structure with its own period
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_ena_scan <= 1'b0;
    end else begin
      r_ena_scan <= (r_scan_cnt == SCAN_TERM);
      if (r_scan_cnt == SCAN_TERM) begin
        r_scan_cnt <= '0;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
    end
  end

  assign ena2hz   = r_ena2hz;
  assign ena_scan = r_ena_scan;

endmodule
